// File: rtl/traffic_lamp_monitor.sv
// Safety monitor and lamp driver behind the traffic light controller: decodes NS/EW
// light codes into registered lamps and drops into flashing red on the first violation.
module traffic_lamp_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_DWELL  = 31,
    parameter int FLASH_HALF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ns_code,
    input  logic [2:0] ew_code,
    output logic       ns_red,
    output logic       ns_yel,
    output logic       ns_grn,
    output logic       ew_red,
    output logic       ew_yel,
    output logic       ew_grn,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int DW = $clog2(MAX_DWELL + 2);
    localparam int FW = $clog2(FLASH_HALF) + 1;

    localparam logic [2:0]    C_R        = 3'd0;
    localparam logic [2:0]    C_Y        = 3'd1;
    localparam logic [2:0]    C_G        = 3'd2;
    localparam logic [DW-1:0] DWELL_SAT  = DW'(MAX_DWELL + 1);
    localparam logic [DW-1:0] MIN_Y_C    = DW'(MIN_YELLOW);
    localparam logic [DW-1:0] MIN_G_C    = DW'(MIN_GREEN);
    localparam logic [FW-1:0] FLASH_ON   = FW'(FLASH_HALF);
    localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLASH} state_t;

    state_t        state_q, state_d;
    logic [2:0]    ns_prev_q, ns_prev_d, ew_prev_q, ew_prev_d;
    logic [DW-1:0] ns_dwell_q, ns_dwell_d, ew_dwell_q, ew_dwell_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic [2:0]    ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;  // {grn, yel, red}
    logic          fault_q, fault_d;
    logic [2:0]    fault_code_q, fault_code_d;

    logic [DW-1:0] ns_dwell_nx, ew_dwell_nx;
    logic          legal, conflict, bad_trans, short_yel, short_grn, stuck;
    logic [2:0]    viol_code;

    function automatic logic [2:0] decode(input logic [2:0] code);
        case (code)
            C_R:     decode = 3'b001;
            C_Y:     decode = 3'b010;
            C_G:     decode = 3'b100;
            default: decode = 3'b000;
        endcase
    endfunction

    function automatic logic bad_step(input logic [2:0] prev, input logic [2:0] code);
        bad_step = (code != prev) &&
                   !((prev == C_R && code == C_G) ||
                     (prev == C_G && code == C_Y) ||
                     (prev == C_Y && code == C_R));
    endfunction

    function automatic logic [DW-1:0] dwell_next(input logic [2:0] prev, input logic [2:0] code,
                                                 input logic [DW-1:0] dwell);
        if (code != prev)           dwell_next = DW'(1);
        else if (dwell == DWELL_SAT) dwell_next = dwell;
        else                         dwell_next = dwell + 1'b1;
    endfunction

    // Violation detection against the previous sample; lowest code number wins.
    always_comb begin
        ns_dwell_nx = dwell_next(ns_prev_q, ns_code, ns_dwell_q);
        ew_dwell_nx = dwell_next(ew_prev_q, ew_code, ew_dwell_q);
        legal     = (ns_code <= C_G) && (ew_code <= C_G);
        conflict  = (ns_code != C_R) && (ew_code != C_R);
        bad_trans = bad_step(ns_prev_q, ns_code) || bad_step(ew_prev_q, ew_code);
        short_yel = (ns_prev_q == C_Y && ns_code == C_R && ns_dwell_q < MIN_Y_C) ||
                    (ew_prev_q == C_Y && ew_code == C_R && ew_dwell_q < MIN_Y_C);
        short_grn = (ns_prev_q == C_G && ns_code == C_Y && ns_dwell_q < MIN_G_C) ||
                    (ew_prev_q == C_G && ew_code == C_Y && ew_dwell_q < MIN_G_C);
        stuck     = (ns_dwell_nx == DWELL_SAT) || (ew_dwell_nx == DWELL_SAT);

        viol_code = 3'd0;
        if (conflict)       viol_code = 3'd1;
        else if (!legal)    viol_code = 3'd2;
        else if (bad_trans) viol_code = 3'd3;
        else if (short_yel) viol_code = 3'd4;
        else if (short_grn) viol_code = 3'd5;
        else if (stuck)     viol_code = 3'd6;
    end

    // NOTE: every variable gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        ns_prev_d    = ns_prev_q;
        ew_prev_d    = ew_prev_q;
        ns_dwell_d   = ns_dwell_q;
        ew_dwell_d   = ew_dwell_q;
        flash_cnt_d  = flash_cnt_q;
        ns_lamp_d    = ns_lamp_q;
        ew_lamp_d    = ew_lamp_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        case (state_q)
            ST_INIT: begin
                if (legal && (ns_code == C_R || ew_code == C_R)) begin
                    state_d    = ST_RUN;
                    ns_prev_d  = ns_code;
                    ew_prev_d  = ew_code;
                    ns_dwell_d = DW'(1);
                    ew_dwell_d = DW'(1);
                    ns_lamp_d  = decode(ns_code);
                    ew_lamp_d  = decode(ew_code);
                end
            end
            ST_RUN: begin
                ns_prev_d  = ns_code;
                ew_prev_d  = ew_code;
                ns_dwell_d = ns_dwell_nx;
                ew_dwell_d = ew_dwell_nx;
                if (viol_code != 3'd0) begin
                    state_d      = ST_FLASH;
                    fault_d      = 1'b1;
                    fault_code_d = viol_code;
                    flash_cnt_d  = '0;
                    ns_lamp_d    = 3'b001;
                    ew_lamp_d    = 3'b001;
                end else begin
                    ns_lamp_d = decode(ns_code);
                    ew_lamp_d = decode(ew_code);
                end
            end
            ST_FLASH: begin
                // The violation edge is the first on-cycle; count then toggles reds every FLASH_HALF.
                flash_cnt_d = (flash_cnt_q == FLASH_LAST) ? '0 : flash_cnt_q + 1'b1;
                ns_lamp_d   = {2'b00, flash_cnt_d < FLASH_ON};
                ew_lamp_d   = {2'b00, flash_cnt_d < FLASH_ON};
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            ns_prev_q    <= C_R;
            ew_prev_q    <= C_R;
            ns_dwell_q   <= '0;
            ew_dwell_q   <= '0;
            flash_cnt_q  <= '0;
            ns_lamp_q    <= 3'b001;
            ew_lamp_q    <= 3'b001;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            ns_prev_q    <= ns_prev_d;
            ew_prev_q    <= ew_prev_d;
            ns_dwell_q   <= ns_dwell_d;
            ew_dwell_q   <= ew_dwell_d;
            flash_cnt_q  <= flash_cnt_d;
            ns_lamp_q    <= ns_lamp_d;
            ew_lamp_q    <= ew_lamp_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign {ns_grn, ns_yel, ns_red} = ns_lamp_q;
    assign {ew_grn, ew_yel, ew_red} = ew_lamp_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed testbench for traffic_lamp_monitor: legal cycling, each fault code,
// priority, flash cadence and asynchronous reset out of FLASH.
module tb_traffic_lamp_monitor;

    localparam logic [2:0] R = 3'd0;
    localparam logic [2:0] Y = 3'd1;
    localparam logic [2:0] G = 3'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ns_code = R;
    logic [2:0] ew_code = R;
    logic       ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn;
    logic       fault;
    logic [2:0] fault_code;
    logic [5:0] lamps;

    int total = 0;
    int bad   = 0;

    traffic_lamp_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .ns_code    (ns_code),
        .ew_code    (ew_code),
        .ns_red     (ns_red),
        .ns_yel     (ns_yel),
        .ns_grn     (ns_grn),
        .ew_red     (ew_red),
        .ew_yel     (ew_yel),
        .ew_grn     (ew_grn),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    assign lamps = {ns_grn, ns_yel, ns_red, ew_grn, ew_yel, ew_red};

    // Expected one-hot lamp vector {ns g,y,r, ew g,y,r} for a pair of light codes.
    function automatic logic [5:0] exp_lamps(input logic [2:0] ns, input logic [2:0] ew);
        logic [2:0] n, e;
        n = (ns == R) ? 3'b001 : (ns == Y) ? 3'b010 : (ns == G) ? 3'b100 : 3'b000;
        e = (ew == R) ? 3'b001 : (ew == Y) ? 3'b010 : (ew == G) ? 3'b100 : 3'b000;
        return {n, e};
    endfunction

    task automatic step(input logic [2:0] ns, input logic [2:0] ew);
        ns_code = ns;
        ew_code = ew;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ns_code = R;
        ew_code = R;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (lamps !== 6'b001_001) begin
            bad++; $display("FAIL reset_lamps got=%b want=%b", lamps, 6'b001_001);
        end
        total++;
        if (fault !== 1'b0 || fault_code !== 3'd0) begin
            bad++; $display("FAIL reset_fault got=%b/%0d want=0/0", fault, fault_code);
        end
    endtask

    logic [2:0] seq_ns [7] = '{R, G, Y, R, R, R, R};
    logic [2:0] seq_ew [7] = '{R, R, R, R, G, Y, R};
    int         seq_n  [7] = '{2, 7, 2, 2, 7, 2, 2};

    task automatic test_legal_cycle();
        int errs = 0;
        apply_reset();
        for (int rep = 0; rep < 3; rep++) begin
            for (int p = 0; p < 7; p++) begin
                for (int k = 0; k < seq_n[p]; k++) begin
                    step(seq_ns[p], seq_ew[p]);
                    total++;
                    if (lamps !== exp_lamps(seq_ns[p], seq_ew[p]) || fault !== 1'b0) begin
                        bad++; errs++;
                        if (errs < 5)
                            $display("FAIL legal_cycle rep=%0d ph=%0d lamps=%b fault=%b want lamps=%b fault=0",
                                     rep, p, lamps, fault, exp_lamps(seq_ns[p], seq_ew[p]));
                    end
                end
            end
        end
    endtask

    task automatic test_conflict_flash();
        logic [2:0] junk_ns [8] = '{G, Y, 3'd5, G, R, 3'd7, Y, G};
        logic [2:0] junk_ew [8] = '{G, G, 3'd6, Y, R, G, Y, R};
        logic       on;
        apply_reset();
        step(R, R);
        step(G, G);
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || lamps !== 6'b001_001) begin
            bad++; $display("FAIL conflict got fault=%b code=%0d lamps=%b want 1/1/001001",
                            fault, fault_code, lamps);
        end
        for (int i = 1; i <= 8; i++) begin
            step(junk_ns[i-1], junk_ew[i-1]);
            on = ((i % 4) < 2);
            total++;
            if (lamps !== {2'b00, on, 2'b00, on} || fault !== 1'b1 || fault_code !== 3'd1) begin
                bad++; $display("FAIL flash_cycle%0d got lamps=%b code=%0d want lamps=%b code=1",
                                i, lamps, fault_code, {2'b00, on, 2'b00, on});
            end
        end
    endtask

    task automatic test_skipped_yellow();
        apply_reset();
        step(R, R);
        repeat (5) step(G, R);
        total++;
        if (fault !== 1'b0) begin
            bad++; $display("FAIL skip_yel_pre got fault=%b want 0", fault);
        end
        step(R, R);
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd3) begin
            bad++; $display("FAIL skip_yel got fault=%b code=%0d want 1/3", fault, fault_code);
        end
    endtask

    task automatic test_illegal_code();
        apply_reset();
        step(R, R);
        step(3'd5, R);
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || lamps !== 6'b001_001) begin
            bad++; $display("FAIL illegal_code got fault=%b code=%0d lamps=%b want 1/2/001001",
                            fault, fault_code, lamps);
        end
    endtask

    task automatic test_short_yellow();
        apply_reset();
        step(R, R);
        repeat (5) step(G, R);
        step(Y, R);
        total++;
        if (fault !== 1'b0 || lamps !== exp_lamps(Y, R)) begin
            bad++; $display("FAIL short_yel_pre got fault=%b lamps=%b want 0/%b", fault, lamps, exp_lamps(Y, R));
        end
        step(R, R);
        total++;
        if (fault_code !== 3'd4) begin
            bad++; $display("FAIL short_yel got code=%0d want 4", fault_code);
        end
    endtask

    task automatic test_short_green();
        apply_reset();
        step(R, R);
        repeat (3) step(G, R);
        total++;
        if (fault !== 1'b0) begin
            bad++; $display("FAIL short_grn_pre got fault=%b want 0", fault);
        end
        step(Y, R);
        total++;
        if (fault_code !== 3'd5) begin
            bad++; $display("FAIL short_grn got code=%0d want 5", fault_code);
        end
    endtask

    task automatic test_stuck();
        apply_reset();
        repeat (31) step(R, R);
        total++;
        if (fault !== 1'b0) begin
            bad++; $display("FAIL stuck_31 got fault=%b want 0", fault);
        end
        step(R, R);
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd6) begin
            bad++; $display("FAIL stuck_32 got fault=%b code=%0d want 1/6", fault, fault_code);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        repeat (31) step(G, R);
        total++;
        if (fault !== 1'b0 || lamps !== exp_lamps(G, R)) begin
            bad++; $display("FAIL prio_pre got fault=%b lamps=%b want 0/%b", fault, lamps, exp_lamps(G, R));
        end
        step(G, G);
        total++;
        if (fault_code !== 3'd1) begin
            bad++; $display("FAIL prio got code=%0d want 1", fault_code);
        end
    endtask

    task automatic test_reset_mid_flash();
        apply_reset();
        step(R, R);
        step(G, G);
        step(G, G);
        step(G, G);
        total++;
        if (lamps !== 6'b000_000) begin
            bad++; $display("FAIL flash_off_phase got lamps=%b want 000000", lamps);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (lamps !== 6'b001_001 || fault !== 1'b0 || fault_code !== 3'd0) begin
            bad++; $display("FAIL async_reset got lamps=%b fault=%b code=%0d want 001001/0/0",
                            lamps, fault, fault_code);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3'd5, 3'd6);
        step(3'd7, R);
        step(G, G);
        total++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || lamps !== 6'b001_001) begin
            bad++; $display("FAIL init_ignore got fault=%b code=%0d lamps=%b want 0/0/001001",
                            fault, fault_code, lamps);
        end
        step(G, R);
        total++;
        if (ns_grn !== 1'b1 || ew_red !== 1'b1 || lamps !== exp_lamps(G, R) || fault !== 1'b0) begin
            bad++; $display("FAIL rerun got lamps=%b fault=%b want %b/0", lamps, fault, exp_lamps(G, R));
        end
        step(G, G);
        total++;
        if (fault_code !== 3'd1) begin
            bad++; $display("FAIL rerun_monitor got code=%0d want 1", fault_code);
        end
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_conflict_flash();
        test_skipped_yellow();
        test_illegal_code();
        test_short_yellow();
        test_short_green();
        test_stuck();
        test_priority();
        test_reset_mid_flash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Safety monitor and lamp driver placed directly downstream of the traffic light controller. It consumes the controller's per-direction light codes (NS, EW) and decodes them into six registered one-hot lamp drives. It checks every cycle for conflicting, illegal or mistimed light sequences. On the first violation it latches a fault code and forces both directions into flashing red until reset.

## Interface
Parameters:
- MIN_GREEN, 4: minimum consecutive sampled cycles a direction must hold G before going to Y.
- MIN_YELLOW, 2: minimum consecutive sampled cycles of Y before going to R.
- MAX_DWELL, 31: maximum consecutive sampled cycles any single code may be held.
- FLASH_HALF, 2: cycles lamps are on, then off, in flash mode.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ns_code  in  3  NS light code: R=0, Y=1, G=2; values 3..7 are illegal.
- ew_code  in  3  EW light code, same encoding as ns_code.
- ns_red, ns_yel, ns_grn  out  1 each  NS lamp drives.
- ew_red, ew_yel, ew_grn  out  1 each  EW lamp drives.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first fault detected; 0 means no fault.

## Operation
- States:
  - INIT: entered on reset.
  - RUN: normal monitoring.
  - FLASH: terminal; only rst leaves it.
- Reset values:
  - State INIT.
  - ns_red=1, ew_red=1; all other lamps 0.
  - fault=0, fault_code=0.
  - Dwell counters 0.
- INIT:
  - Lamps stay in their reset values.
  - Goes to RUN at the first edge where both codes are legal (0..2) and at least one is R.
  - At that edge: previous-code registers load the sample, both dwell counters load 1, lamps show the decoded sample.
  - Transition and timing checks are not applied to this first sample. Illegal samples in INIT raise no fault.
- RUN, at every edge:
  - Each direction's dwell counter increments, saturating at MAX_DWELL+1, if its code equals the previous code; otherwise it reloads 1.
  - Lamps show the one-hot decode of the sample.
- Checks in RUN, evaluated on the current sample against the previous-code registers and dwell counters:
  - Code 1, conflict: neither direction is R.
  - Code 2, illegal code: either code is 3..7.
  - Code 3, illegal transition: either direction changes by anything other than R->G, G->Y or Y->R.
  - Code 4, short yellow: a direction goes Y->R with dwell < MIN_YELLOW.
  - Code 5, short green: a direction goes G->Y with dwell < MIN_GREEN.
  - Code 6, stuck: either dwell counter would reach MAX_DWELL+1.
- Simultaneous violations: the lowest code number wins. Both directions are checked every cycle.
- On any violation:
  - At the same edge the state goes to FLASH, fault=1 and fault_code is latched.
  - Further violations are ignored.
- FLASH:
  - ns_red and ew_red both =1 for FLASH_HALF cycles, then both =0 for FLASH_HALF cycles, repeating. The first edge in FLASH starts the on phase.
  - Yellow and green lamps are 0.
  - Input codes are ignored.
- Counter widths:
  - Dwell counter: $clog2(MAX_DWELL+2) bits.
  - Flash counter: $clog2(FLASH_HALF)+1 bits.
  - No counter wraps.

## Timing
- All outputs are registered.
- Latency: a sample taken at edge k is visible on the lamps, and as fault and fault_code, immediately after edge k.
- rst asserted mid-operation, including in FLASH, clears all outputs to their reset values asynchronously. The monitor then re-enters INIT.
- The first edge after rst deasserts is an INIT evaluation.
- No handshake. Inputs are sampled every cycle and must be stable around the clk edge.

## Test plan
- Reset then legal cycle, sampled on successive edges:
  - Sequence: (R,R)x2, (G,R)x7, (Y,R)x2, (R,R)x2, (R,G)x7, (R,Y)x2, (R,R)x2, repeated 3 times.
  - Required: lamps track each sample one edge later, fault stays 0.
- Conflict:
  - Stimulus: after entering RUN, drive (G,G).
  - Required, at that edge: fault=1, fault_code=1, ns_red=ew_red=1.
  - Then the red lamps toggle every 2 cycles (on 2, off 2) and yellow and green stay 0 whatever the inputs do.
- Skipped yellow:
  - Stimulus: NS G for 5 cycles, then NS R with EW R.
  - Required: fault_code=3.
  - Variant: drive ns_code=5 in RUN; required fault_code=2.
- Short phases:
  - Stimulus: NS G for 5 samples, Y for 1 sample, then R.
  - Required: fault_code=4 at the R edge.
  - Stimulus: NS G for 3 samples, then Y.
  - Required: fault_code=5.
- Stuck and priority:
  - Stimulus: hold (R,R) for 32 samples.
  - Required: fault_code=6 at the 32nd sample.
  - Stimulus: (G,G) in the same cycle as a G->G dwell overflow.
  - Required: fault_code=1.
- Reset mid-FLASH:
  - Stimulus: assert rst between edges while in FLASH.
  - Required: outputs return to their reset values immediately, without waiting for an edge.
  - Stimulus: after rst deasserts, drive illegal codes.
  - Required: no fault.
  - Stimulus: then drive (G,R).
  - Required: RUN, with ns_grn=1 and ew_red=1.
